// File: rtl/id_scoreboard_pkg.sv
// Shared defaults, per-counter status bundle and packed-port slicing helper
// for the decode-stage register hazard scoreboard.
package id_scoreboard_pkg;

  localparam int SB_NREGS  = 32;
  localparam int SB_PEND_W = 2;
  localparam int SB_NSRC   = 2;
  localparam int SB_NCLR   = 2;

  typedef struct packed {
    logic nonzero;
    logic full;
    logic uflow;
  } sb_cnt_status_t;

  // LSB of port 'port' inside a bus that packs equal-width fields back to back.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Decoder/issue/clear bundle between the decode stage and the hazard scoreboard.
interface id_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int NSRC  = 2,
  parameter int NCLR  = 2
);
  localparam int RADDR_W = $clog2(NREGS);

  logic                      clk_en_i;
  logic                      flush_i;
  logic                      chk_valid_i;
  logic [NSRC-1:0]           chk_src_rd_i;
  logic [NSRC*RADDR_W-1:0]   chk_src_addr_i;
  logic                      chk_dst_wr_i;
  logic                      chk_dst_load_i;
  logic [RADDR_W-1:0]        chk_dst_addr_i;
  logic                      issue_i;
  logic [NCLR-1:0]           clr_i;
  logic [NCLR*RADDR_W-1:0]   clr_addr_i;
  logic                      stall_o;
  logic                      busy_o;
  logic                      err_o;

  modport master (
    output clk_en_i, flush_i, chk_valid_i, chk_src_rd_i, chk_src_addr_i,
           chk_dst_wr_i, chk_dst_load_i, chk_dst_addr_i, issue_i, clr_i, clr_addr_i,
    input  stall_o, busy_o, err_o
  );

  modport slave (
    input  clk_en_i, flush_i, chk_valid_i, chk_src_rd_i, chk_src_addr_i,
           chk_dst_wr_i, chk_dst_load_i, chk_dst_addr_i, issue_i, clr_i, clr_addr_i,
    output stall_o, busy_o, err_o
  );

endinterface

// File: rtl/id_scoreboard_sb_counter.sv
// One saturating up/down pending-load counter: +inc, -dec_count per cycle,
// clamped at zero (flagging uflow) and at its maximum.
module sb_counter #(
  parameter int PEND_W = 2,
  parameter int DEC_W  = 2
) (
  input  logic             clk_i,
  input  logic             resetb_i,
  input  logic             en,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec_count,
  input  logic             flush,
  output logic             nonzero,
  output logic             full,
  output logic             uflow
);
  localparam int SUM_W = ((PEND_W > DEC_W) ? PEND_W : DEC_W) + 1;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_reg;
  logic [PEND_W-1:0] cnt_next;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  dec_ext;
  logic [SUM_W-1:0]  diff;

  always_comb begin
    sum      = SUM_W'(cnt_reg) + SUM_W'(inc);
    dec_ext  = SUM_W'(dec_count);
    diff     = sum - dec_ext;
    cnt_next = cnt_reg;
    if (dec_ext > sum) begin
      cnt_next = '0;
    end else if (diff > SUM_W'(CNT_MAX)) begin
      cnt_next = CNT_MAX;
    end else begin
      cnt_next = diff[PEND_W-1:0];
    end
  end

  // A clear that lands on an empty counter is an error even if an increment
  // in the same cycle would arithmetically cover it.
  assign uflow   = ~flush & (dec_count != '0) & ((cnt_reg == '0) | (dec_ext > sum));
  assign nonzero = (cnt_reg != '0);
  assign full    = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (flush) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register hazard scoreboard: per-register pending-load counters,
// combinational stall on RAW / WAW-vs-load / saturation, sticky error flag.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int NREGS  = SB_NREGS,
  parameter int PEND_W = SB_PEND_W,
  parameter int NSRC   = SB_NSRC,
  parameter int NCLR   = SB_NCLR
) (
  input logic            clk_i,
  input logic            resetb_i,
  id_scoreboard_if.slave sb
);
  localparam int RADDR_W = $clog2(NREGS);
  localparam int DEC_W   = $clog2(NCLR + 1);

  // Bit 0 stands for x0 and is tied low so it can never hit.
  logic [NREGS-1:0] nonzero_all;
  logic [NREGS-1:0] full_all;
  logic [NREGS-1:0] err_all;

  assign nonzero_all[0] = 1'b0;
  assign full_all[0]    = 1'b0;
  assign err_all[0]     = 1'b0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    logic             inc;
    logic [DEC_W-1:0] dec_count;
    sb_cnt_status_t   st;

    assign inc = sb.issue_i & sb.chk_dst_wr_i & sb.chk_dst_load_i &
                 (sb.chk_dst_addr_i == RADDR_W'(gi));

    always_comb begin
      dec_count = '0;
      for (int p = 0; p < NCLR; p++) begin
        if (sb.clr_i[p] && (sb.clr_addr_i[port_lsb(p, RADDR_W) +: RADDR_W] == RADDR_W'(gi))) begin
          dec_count = dec_count + DEC_W'(1);
        end
      end
    end

    sb_counter #(
      .PEND_W (PEND_W),
      .DEC_W  (DEC_W)
    ) u_cnt (
      .clk_i     (clk_i),
      .resetb_i  (resetb_i),
      .en        (sb.clk_en_i),
      .inc       (inc),
      .dec_count (dec_count),
      .flush     (sb.flush_i),
      .nonzero   (st.nonzero),
      .full      (st.full),
      .uflow     (st.uflow)
    );

    assign nonzero_all[gi] = st.nonzero;
    assign full_all[gi]    = st.full;
    // Increment into a saturated counter with no offsetting clear.
    assign err_all[gi]     = st.uflow | (inc & st.full & (dec_count == '0) & ~sb.flush_i);
  end

  logic               src_hit;
  logic [RADDR_W-1:0] src_addr;
  logic               waw_hit;
  logic               sat_hit;

  always_comb begin
    src_hit  = 1'b0;
    src_addr = '0;
    for (int k = 0; k < NSRC; k++) begin
      src_addr = sb.chk_src_addr_i[port_lsb(k, RADDR_W) +: RADDR_W];
      if (sb.chk_src_rd_i[k] && nonzero_all[src_addr]) begin
        src_hit = 1'b1;
      end
    end
  end

  assign waw_hit    = sb.chk_dst_wr_i & ~sb.chk_dst_load_i & nonzero_all[sb.chk_dst_addr_i];
  assign sat_hit    = sb.chk_dst_wr_i &  sb.chk_dst_load_i & full_all[sb.chk_dst_addr_i];
  assign sb.stall_o = sb.chk_valid_i & (src_hit | waw_hit | sat_hit);

  logic busy_reg;
  logic err_reg;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      busy_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else if (sb.clk_en_i) begin
      busy_reg <= |nonzero_all;
      if (|err_all) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign sb.busy_o = busy_reg;
  assign sb.err_o  = err_reg;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus a randomized
// run against a counter-array reference model.
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  localparam int NR   = SB_NREGS;
  localparam int MAXC = (1 << SB_PEND_W) - 1;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  id_scoreboard_if #(.NREGS(NR), .NSRC(SB_NSRC), .NCLR(SB_NCLR)) sb ();

  id_scoreboard #(
    .NREGS  (NR),
    .PEND_W (SB_PEND_W),
    .NSRC   (SB_NSRC),
    .NCLR   (SB_NCLR)
  ) dut (
    .clk_i    (clk),
    .resetb_i (resetb),
    .sb       (sb)
  );

  int tests = 0;
  int fails = 0;
  int cnt_m [NR];
  bit busy_m;
  bit err_m;

  task automatic drive_chk(input bit v, input bit [1:0] rd, input bit [4:0] s0, input bit [4:0] s1,
                           input bit wr, input bit ld, input bit [4:0] dst);
    sb.chk_valid_i    = v;
    sb.chk_src_rd_i   = rd;
    sb.chk_src_addr_i = {s1, s0};
    sb.chk_dst_wr_i   = wr;
    sb.chk_dst_load_i = ld;
    sb.chk_dst_addr_i = dst;
  endtask

  task automatic drive_act(input bit iss, input bit [1:0] clr, input bit [4:0] c0, input bit [4:0] c1,
                           input bit fl, input bit en);
    sb.issue_i    = iss;
    sb.clr_i      = clr;
    sb.clr_addr_i = {c1, c0};
    sb.flush_i    = fl;
    sb.clk_en_i   = en;
  endtask

  task automatic idle();
    drive_chk(0, 2'b00, 0, 0, 0, 0, 0);
    drive_act(0, 2'b00, 0, 0, 0, 1);
  endtask

  function automatic bit model_stall();
    bit [4:0] a;
    if (!sb.chk_valid_i) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      a = sb.chk_src_addr_i[k*5 +: 5];
      if (sb.chk_src_rd_i[k] && a != 0 && cnt_m[a] != 0) return 1'b1;
    end
    if (sb.chk_dst_wr_i && sb.chk_dst_addr_i != 0) begin
      if (!sb.chk_dst_load_i && cnt_m[sb.chk_dst_addr_i] != 0) return 1'b1;
      if (sb.chk_dst_load_i && cnt_m[sb.chk_dst_addr_i] == MAXC) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) cnt_m[r] = 0;
    busy_m = 1'b0;
    err_m  = 1'b0;
  endfunction

  // Advance one clock; the model applies the same edge using the driven inputs.
  task automatic tick();
    int v;
    int dec;
    bit any;
    @(posedge clk);
    if (resetb && sb.clk_en_i) begin
      any = 1'b0;
      for (int r = 1; r < NR; r++) if (cnt_m[r] != 0) any = 1'b1;
      busy_m = any;
      if (sb.flush_i) begin
        for (int r = 0; r < NR; r++) cnt_m[r] = 0;
      end else begin
        for (int r = 1; r < NR; r++) begin
          dec = 0;
          for (int p = 0; p < 2; p++)
            if (sb.clr_i[p] && sb.clr_addr_i[p*5 +: 5] == 5'(r)) dec++;
          v = cnt_m[r] - dec;
          if (sb.issue_i && sb.chk_dst_wr_i && sb.chk_dst_load_i && sb.chk_dst_addr_i == 5'(r)) v++;
          if (dec > 0 && cnt_m[r] == 0) err_m = 1'b1;
          if (v < 0) begin v = 0; err_m = 1'b1; end
          if (v > MAXC) begin v = MAXC; err_m = 1'b1; end
          cnt_m[r] = v;
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    idle();
    resetb = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    resetb = 1'b0;
    model_reset();
    tick();
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall[%0d]: got %b want 0", i, sb.stall_o); end
      tests++; if (sb.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b want 0", i, sb.busy_o); end
      tests++; if (sb.err_o !== 1'b0) begin fails++; $display("FAIL reset_err[%0d]: got %b want 0", i, sb.err_o); end
    end
  endtask

  task automatic test_load_use();
    drive_chk(1, 2'b00, 0, 0, 1, 1, 5);
    drive_act(1, 2'b00, 0, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL load_use issue: stall got %b want 0", sb.stall_o); end
    tick();
    drive_chk(1, 2'b01, 5, 0, 1, 0, 6);
    drive_act(0, 2'b00, 0, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b1) begin fails++; $display("FAIL load_use raw: stall got %b want 1", sb.stall_o); end
    tests++; if (sb.busy_o !== 1'b0) begin fails++; $display("FAIL load_use busy_lag: got %b want 0", sb.busy_o); end
    tick();
    tests++; if (sb.busy_o !== 1'b1) begin fails++; $display("FAIL load_use busy_set: got %b want 1", sb.busy_o); end
    drive_act(0, 2'b10, 0, 5, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b1) begin fails++; $display("FAIL load_use no_bypass: stall got %b want 1", sb.stall_o); end
    tick();
    drive_act(0, 2'b00, 0, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL load_use released: stall got %b want 0", sb.stall_o); end
    tests++; if (sb.busy_o !== 1'b1) begin fails++; $display("FAIL load_use busy_hold: got %b want 1", sb.busy_o); end
    tick();
    tests++; if (sb.busy_o !== 1'b0) begin fails++; $display("FAIL load_use busy_fall: got %b want 0", sb.busy_o); end
    tests++; if (sb.err_o !== 1'b0) begin fails++; $display("FAIL load_use err: got %b want 0", sb.err_o); end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      drive_chk(1, 2'b00, 0, 0, 1, 1, 7);
      drive_act(1, 2'b00, 0, 0, 0, 1);
      #1;
      tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL sat fill[%0d]: stall got %b want 0", i, sb.stall_o); end
      tick();
    end
    drive_act(0, 2'b00, 0, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b1) begin fails++; $display("FAIL sat full: stall got %b want 1", sb.stall_o); end
    drive_act(0, 2'b01, 7, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b1) begin fails++; $display("FAIL sat no_bypass: stall got %b want 1", sb.stall_o); end
    tick();
    drive_act(0, 2'b00, 0, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL sat released: stall got %b want 0", sb.stall_o); end
    drive_chk(1, 2'b10, 0, 7, 0, 0, 0);
    #1;
    tests++; if (sb.stall_o !== 1'b1) begin fails++; $display("FAIL sat cnt2_raw: stall got %b want 1", sb.stall_o); end
    drive_chk(0, 2'b00, 0, 0, 0, 0, 0);
    drive_act(0, 2'b11, 7, 7, 0, 1);
    tick();
    drive_act(0, 2'b00, 0, 0, 0, 1);
    drive_chk(1, 2'b01, 7, 0, 0, 0, 0);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL sat drained: stall got %b want 0", sb.stall_o); end
    tick();
    tests++; if (sb.err_o !== 1'b0) begin fails++; $display("FAIL sat err: got %b want 0", sb.err_o); end
    idle();
  endtask

  task automatic test_multi_clear();
    for (int i = 0; i < 2; i++) begin
      drive_chk(1, 2'b00, 0, 0, 1, 1, 9);
      drive_act(1, 2'b00, 0, 0, 0, 1);
      tick();
    end
    drive_chk(1, 2'b00, 0, 0, 1, 1, 9);
    drive_act(1, 2'b11, 9, 9, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL mclr issue: stall got %b want 0", sb.stall_o); end
    tick();
    drive_act(0, 2'b00, 0, 0, 0, 1);
    drive_chk(1, 2'b01, 9, 0, 0, 0, 0);
    #1;
    tests++; if (sb.stall_o !== 1'b1) begin fails++; $display("FAIL mclr cnt1_raw: stall got %b want 1", sb.stall_o); end
    tests++; if (sb.err_o !== 1'b0) begin fails++; $display("FAIL mclr err: got %b want 0", sb.err_o); end
    drive_chk(0, 2'b00, 0, 0, 0, 0, 0);
    drive_act(0, 2'b01, 9, 0, 0, 1);
    tick();
    drive_act(0, 2'b00, 0, 0, 0, 1);
    drive_chk(1, 2'b01, 9, 0, 0, 0, 0);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL mclr drained: stall got %b want 0", sb.stall_o); end
    tick();
    tests++; if (sb.err_o !== 1'b0) begin fails++; $display("FAIL mclr drain_err: got %b want 0", sb.err_o); end
    idle();
  endtask

  task automatic test_error_flush();
    drive_act(0, 2'b01, 3, 0, 0, 1);
    tick();
    drive_act(0, 2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tests++; if (sb.err_o !== 1'b1) begin fails++; $display("FAIL errf sticky[%0d]: got %b want 1", i, sb.err_o); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive_chk(1, 2'b00, 0, 0, 1, 1, 4);
      drive_act(1, 2'b00, 0, 0, 0, 1);
      tick();
    end
    tests++; if (sb.busy_o !== 1'b1) begin fails++; $display("FAIL errf busy_before: got %b want 1", sb.busy_o); end
    drive_act(1, 2'b10, 0, 4, 1, 1);
    tick();
    drive_act(0, 2'b00, 0, 0, 0, 1);
    drive_chk(1, 2'b01, 4, 0, 0, 0, 0);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL errf flushed: stall got %b want 0", sb.stall_o); end
    tick();
    tests++; if (sb.busy_o !== 1'b0) begin fails++; $display("FAIL errf busy_fall: got %b want 0", sb.busy_o); end
    tests++; if (sb.err_o !== 1'b1) begin fails++; $display("FAIL errf err_kept: got %b want 1", sb.err_o); end
    idle();
  endtask

  task automatic test_x0_clk_en();
    apply_reset();
    drive_chk(1, 2'b11, 0, 0, 1, 1, 0);
    drive_act(1, 2'b11, 0, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL x0 load: stall got %b want 0", sb.stall_o); end
    tick();
    drive_chk(1, 2'b00, 0, 0, 1, 0, 0);
    drive_act(0, 2'b00, 0, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL x0 waw: stall got %b want 0", sb.stall_o); end
    tick();
    tests++; if (sb.busy_o !== 1'b0) begin fails++; $display("FAIL x0 busy: got %b want 0", sb.busy_o); end
    tests++; if (sb.err_o !== 1'b0) begin fails++; $display("FAIL x0 err: got %b want 0", sb.err_o); end
    drive_chk(1, 2'b00, 0, 0, 1, 1, 5);
    drive_act(1, 2'b00, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_act(1, 2'b00, 0, 0, 0, 0);
      #1;
      tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL en hold[%0d]: stall got %b want 0", i, sb.stall_o); end
      tick();
    end
    drive_chk(1, 2'b01, 5, 0, 0, 0, 0);
    drive_act(0, 2'b00, 0, 0, 0, 0);
    #1;
    tests++; if (sb.stall_o !== 1'b1) begin fails++; $display("FAIL en stall_live: got %b want 1", sb.stall_o); end
    tick();
    drive_chk(0, 2'b00, 0, 0, 0, 0, 0);
    drive_act(0, 2'b10, 0, 5, 0, 1);
    tick();
    drive_act(0, 2'b00, 0, 0, 0, 1);
    drive_chk(1, 2'b01, 5, 0, 0, 0, 0);
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL en cnt_unchanged: stall got %b want 0", sb.stall_o); end
    tests++; if (sb.err_o !== 1'b0) begin fails++; $display("FAIL en err: got %b want 0", sb.err_o); end
    idle();
  endtask

  task automatic test_async_reset();
    drive_chk(1, 2'b00, 0, 0, 1, 1, 11);
    drive_act(1, 2'b00, 0, 0, 0, 1);
    tick();
    drive_chk(0, 2'b00, 0, 0, 0, 0, 0);
    drive_act(0, 2'b01, 3, 0, 0, 1);
    tick();
    drive_chk(1, 2'b01, 11, 0, 0, 0, 0);
    drive_act(0, 2'b00, 0, 0, 0, 1);
    #1;
    tests++; if (sb.stall_o !== 1'b1) begin fails++; $display("FAIL arst pre_stall: got %b want 1", sb.stall_o); end
    tests++; if (sb.err_o !== 1'b1) begin fails++; $display("FAIL arst pre_err: got %b want 1", sb.err_o); end
    #1;
    resetb = 1'b0;
    model_reset();
    #1;
    tests++; if (sb.stall_o !== 1'b0) begin fails++; $display("FAIL arst stall: got %b want 0", sb.stall_o); end
    tests++; if (sb.busy_o !== 1'b0) begin fails++; $display("FAIL arst busy: got %b want 0", sb.busy_o); end
    tests++; if (sb.err_o !== 1'b0) begin fails++; $display("FAIL arst err: got %b want 0", sb.err_o); end
    @(negedge clk);
    resetb = 1'b1;
    idle();
  endtask

  task automatic test_random();
    bit       v, wr, ld, fl, en, iss;
    bit [1:0] rd, clr;
    bit [4:0] s0, s1, dst, c0, c1;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom % 4) != 0;
      rd  = 2'($urandom_range(3, 0));
      s0  = 5'($urandom_range(7, 0));
      s1  = 5'($urandom_range(7, 0));
      wr  = ($urandom % 4) != 0;
      ld  = ($urandom % 2) != 0;
      dst = 5'($urandom_range(7, 0));
      c0  = 5'($urandom_range(7, 0));
      c1  = 5'($urandom_range(7, 0));
      clr[0] = (cnt_m[c0] > 0 && ($urandom % 2) != 0) || ($urandom % 64) == 0;
      clr[1] = (cnt_m[c1] > 0 && ($urandom % 2) != 0) || ($urandom % 64) == 0;
      fl  = ($urandom % 60) == 0;
      en  = ($urandom % 10) != 0;
      drive_chk(v, rd, s0, s1, wr, ld, dst);
      iss = v && !model_stall() && ($urandom % 2) != 0;
      drive_act(iss, clr, c0, c1, fl, en);
      #1;
      tests++; if (sb.stall_o !== model_stall()) begin fails++; $display("FAIL rand stall[%0d]: got %b want %b", i, sb.stall_o, model_stall()); end
      tick();
      tests++; if (sb.busy_o !== busy_m) begin fails++; $display("FAIL rand busy[%0d]: got %b want %b", i, sb.busy_o, busy_m); end
      tests++; if (sb.err_o !== err_m) begin fails++; $display("FAIL rand err[%0d]: got %b want %b", i, sb.err_o, err_m); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_saturation();
    test_multi_clear();
    test_error_flush();
    test_x0_clk_en();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised register-hazard scoreboard for the decode stage. It replaces the single pending-load bit per register with a per-register up/down counter, so a register can have several loads in flight at once. It accepts any number of clear (load-return or load-cancel) ports and checks any number of source operands. It sits between the decoder and the fetch acknowledge: its `stall_o` gates `pfu_ack_o`, and its clear ports are driven by the EX-stage cancel path and the load/store-queue write-back ports.

## Interface
- `NREGS`, 32: architectural registers; x0 is never tracked.
- `RADDR_W`, `$clog2(NREGS)`: register address width (derived, not overridden).
- `PEND_W`, 2: counter width; at most `2**PEND_W-1` outstanding loads per register.
- `NSRC`, 2: number of source-operand check ports.
- `NCLR`, 2: number of clear ports.

- `clk_i`  in  1  clock.
- `resetb_i`  in  1  reset, asynchronous, active-low.
- `clk_en_i`  in  1  global clock enable; all state holds when low.
- `flush_i`  in  1  zero all counters (used only when the LSQ is flushed as well).
- `chk_valid_i`  in  1  decoded instruction present (`pfu_dav_i`).
- `chk_src_rd_i`  in  NSRC  per-source read enable.
- `chk_src_addr_i`  in  NSRC*RADDR_W  source addresses; source k occupies bits `[k*RADDR_W +: RADDR_W]`.
- `chk_dst_wr_i`  in  1  instruction writes a destination.
- `chk_dst_load_i`  in  1  destination is written by a load (zone LOADQ).
- `chk_dst_addr_i`  in  RADDR_W  destination address.
- `issue_i`  in  1  instruction accepted (`pfu_ack_o`); must never be high while `stall_o` is high.
- `clr_i`  in  NCLR  per-port clear strobe.
- `clr_addr_i`  in  NCLR*RADDR_W  clear addresses, packed the same way as the source addresses.
- `stall_o`  out  1  hazard detected; combinational.
- `busy_o`  out  1  any counter non-zero; registered.
- `err_o`  out  1  sticky; a clear hit a zero counter.

## Operation
- Per-register counter `cnt[r]` for r = 1..NREGS-1. x0 is never set, cleared or checked.
- `stall_o` = `chk_valid_i` AND any of the following:
  - a source k with `chk_src_rd_i[k]`, `addr != 0` and `cnt[addr] != 0`.
  - `chk_dst_wr_i`, `!chk_dst_load_i`, `dst != 0` and `cnt[dst] != 0`. This is a WAW hazard against a load still in flight.
  - `chk_dst_wr_i`, `chk_dst_load_i`, `dst != 0` and `cnt[dst] == 2**PEND_W-1`. The counter is saturated.
- A load may target a register that already has loads pending. This is legal because the LSQ returns loads to the same register in order.
- Increment: `issue_i`, `chk_dst_wr_i`, `chk_dst_load_i` and `dst != 0` add 1 to `cnt[dst]`.
- Decrement: each clear port p with `clr_i[p]` and `addr != 0` subtracts 1. When several ports name the same register in one cycle, the counter decreases by the number of matching ports.
- Net update per register = increment minus the number of matching clears, applied in a single cycle.
- Underflow: when the decrements would take a counter below zero, the counter is clamped at 0 and `err_o` sets. Any clear to a register whose counter is already 0 also sets `err_o`. `err_o` is cleared only by reset.
- Increment at saturation cannot occur, because `stall_o` blocks it. If it does occur, the counter holds at its maximum and `err_o` sets.
- `flush_i` zeroes every counter and overrides any increment or clear in the same cycle. It does not clear `err_o`.
- When `clk_en_i` is low, no state changes, but `stall_o` keeps evaluating.

## Timing
- Reset values: all counters 0; `busy_o` = 0; `err_o` = 0. `stall_o` is 0 while `chk_valid_i` = 0.
- `stall_o` is combinational from the registered counters and the `chk_*` inputs. There is no same-cycle bypass of clears.
  - A clear in cycle n releases a stall from cycle n+1.
- An issue in cycle n makes the register pending, and able to stall, from cycle n+1.
- `busy_o` is registered. It reflects the counters after each update, with one cycle of latency.
- Reset is asynchronous mid-operation: counters and flags clear immediately. There is no partial state.

## Structure
- Add to the shared `riscv_defs.v`:
  - `SB_PEND_W` default.
  - The register address width constant.
  - The packed-port slicing helper macro.
- Sub-module `sb_counter`: one saturating up/down counter with inputs `inc`, `dec_count` (`$clog2(NCLR+1)` bits) and `flush`, and outputs `nonzero`, `full` and `uflow`. The scoreboard generates NREGS-1 instances of it.
- The top level holds the source/destination compare logic, the per-register clear-count reduction, the OR-reduction for `busy_o`, and the `err_o` flop.

## Test plan
- Reset with `clk_en_i`=1 and all strobes low: `stall_o`=0, `busy_o`=0, `err_o`=0 for 10 cycles.
- Issue a load to x5, then check an add reading x5: `stall_o`=1 from the next cycle. `clr_i[1]` on x5 → `stall_o`=0 the cycle after the clear; `busy_o` falls one cycle later.
- `PEND_W`=2: issue three loads to x7, then a fourth load-check to x7 → `stall_o`=1 (saturated). Clear once → `stall_o`=0 next cycle and `cnt[x7]`=2.
- `cnt[x9]`=2, with `clr_i`=2'b11 both on x9 and an issue of a load to x9 in the same cycle → `cnt[x9]`=1 and `err_o`=0.
- Clear x3 while `cnt[x3]`=0 → `err_o`=1 and stays 1. `flush_i` with `cnt[x4]`=2 → `cnt[x4]`=0 and `busy_o`=0; `err_o` still 1.
- Checks, issues and clears that name x0 → no stall, no count change, no error. Hold `clk_en_i`=0 during an issue → `cnt[x5]` unchanged.
